// File: rtl/regfile_sb.sv
// Multi-read-port register file with same-cycle write bypass and a per-register
// scoreboard of pending destination writes; register 0 reads as zero and is never busy.
module regfile_sb #(
    parameter int DATA_W = 32,
    parameter int ADDR_W = 5,
    parameter int N_RD   = 2
) (
    input  logic                     clk_i,
    input  logic                     rst_i,
    input  logic [N_RD*ADDR_W-1:0]   raddr_i,
    output logic [N_RD*DATA_W-1:0]   rdata_o,
    output logic [N_RD-1:0]          rbusy_o,
    input  logic                     wen_i,
    input  logic [ADDR_W-1:0]        waddr_i,
    input  logic [DATA_W-1:0]        wdata_i,
    input  logic                     alloc_i,
    input  logic [ADDR_W-1:0]        alloc_addr_i,
    input  logic                     flush_i,
    output logic [ADDR_W:0]          pend_cnt_o
);

    localparam int DEPTH = 2 ** ADDR_W;

    logic [DATA_W-1:0] regs_reg [DEPTH];
    logic [DEPTH-1:0]  busy_reg;
    logic [DEPTH-1:0]  busy_next;
    logic [ADDR_W:0]   pend_cnt_reg;
    logic [ADDR_W:0]   pend_cnt_next;
    logic              wr_valid;

    // Writes to register 0 are dropped so it stays zero in the array as well.
    assign wr_valid = wen_i && (waddr_i != '0);

    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            for (int i = 0; i < DEPTH; i++) begin
                regs_reg[i] <= '0;
            end
        end else if (wr_valid) begin
            regs_reg[waddr_i] <= wdata_i;
        end
    end

    // Scoreboard priority: flush, then allocation (new producer supersedes the
    // retiring one), then writeback clear, else hold.
    always_comb begin
        busy_next = busy_reg;
        busy_next[0] = 1'b0;
        for (int r = 1; r < DEPTH; r++) begin
            if (flush_i) begin
                busy_next[r] = 1'b0;
            end else if (alloc_i && (alloc_addr_i == ADDR_W'(r))) begin
                busy_next[r] = 1'b1;
            end else if (wen_i && (waddr_i == ADDR_W'(r))) begin
                busy_next[r] = 1'b0;
            end
        end
    end

    // Count is computed from the next state so it matches busy after the edge.
    always_comb begin
        pend_cnt_next = '0;
        for (int r = 1; r < DEPTH; r++) begin
            pend_cnt_next = pend_cnt_next + (ADDR_W + 1)'(busy_next[r]);
        end
    end

    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            busy_reg     <= '0;
            pend_cnt_reg <= '0;
        end else begin
            busy_reg     <= busy_next;
            pend_cnt_reg <= pend_cnt_next;
        end
    end

    assign pend_cnt_o = pend_cnt_reg;

    generate
        for (genvar gi = 0; gi < N_RD; gi++) begin : g_rd
            logic [ADDR_W-1:0] raddr;
            logic              is_zero;
            logic              wr_hit;

            assign raddr   = raddr_i[gi*ADDR_W +: ADDR_W];
            assign is_zero = (raddr == '0);
            assign wr_hit  = wen_i && (waddr_i == raddr);

            assign rdata_o[gi*DATA_W +: DATA_W] = is_zero ? '0 :
                                                  wr_hit  ? wdata_i :
                                                            regs_reg[raddr];
            assign rbusy_o[gi] = !is_zero && busy_reg[raddr] && !wr_hit;
        end
    endgenerate

endmodule

// File: tb/tb_regfile_sb.sv
// Directed bench for regfile_sb: a default 2-port instance and a 4-port 16-bit
// instance, driven step by step with hand-computed expectations.
module tb_regfile_sb;

    logic clk;
    logic rst_i;

    // Default instance (DATA_W=32, ADDR_W=5, N_RD=2)
    logic [9:0]  raddr;
    logic [63:0] rdata;
    logic [1:0]  rbusy;
    logic        wen;
    logic [4:0]  waddr;
    logic [31:0] wdata;
    logic        alloc;
    logic [4:0]  alloc_addr;
    logic        flush;
    logic [5:0]  pend;

    // Wide instance (DATA_W=16, ADDR_W=5, N_RD=4)
    logic [19:0] m_raddr;
    logic [63:0] m_rdata;
    logic [3:0]  m_rbusy;
    logic        m_wen;
    logic [4:0]  m_waddr;
    logic [15:0] m_wdata;
    logic        m_alloc;
    logic [4:0]  m_alloc_addr;
    logic        m_flush;
    logic [5:0]  m_pend;

    int n_cmp = 0;
    int n_err = 0;

    regfile_sb u_dut (
        .clk_i        (clk),
        .rst_i        (rst_i),
        .raddr_i      (raddr),
        .rdata_o      (rdata),
        .rbusy_o      (rbusy),
        .wen_i        (wen),
        .waddr_i      (waddr),
        .wdata_i      (wdata),
        .alloc_i      (alloc),
        .alloc_addr_i (alloc_addr),
        .flush_i      (flush),
        .pend_cnt_o   (pend)
    );

    regfile_sb #(.DATA_W(16), .ADDR_W(5), .N_RD(4)) u_dut4 (
        .clk_i        (clk),
        .rst_i        (rst_i),
        .raddr_i      (m_raddr),
        .rdata_o      (m_rdata),
        .rbusy_o      (m_rbusy),
        .wen_i        (m_wen),
        .waddr_i      (m_waddr),
        .wdata_i      (m_wdata),
        .alloc_i      (m_alloc),
        .alloc_addr_i (m_alloc_addr),
        .flush_i      (m_flush),
        .pend_cnt_o   (m_pend)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Inputs change 1 time unit after the rising edge; checks follow 1 unit later.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    initial begin
        rst_i = 1'b0;
        raddr = '0; wen = 1'b0; waddr = '0; wdata = '0;
        alloc = 1'b0; alloc_addr = '0; flush = 1'b0;
        m_raddr = '0; m_wen = 1'b0; m_waddr = '0; m_wdata = '0;
        m_alloc = 1'b0; m_alloc_addr = '0; m_flush = 1'b0;
        #2;
        check("reset_pend", 64'(pend), 64'd0);
        check("reset_rbusy", 64'(rbusy), 64'd0);
        check("reset_m_pend", 64'(m_pend), 64'd0);
        tick();
        rst_i = 1'b1;

        // Write reg5 and allocate reg7, then reset mid-stream
        wen = 1'b1; waddr = 5'd5; wdata = 32'hDEAD_BEEF; raddr = {5'd0, 5'd5};
        alloc = 1'b1; alloc_addr = 5'd7;
        #1;
        check("bypass_r5", 64'(rdata[31:0]), 64'hDEAD_BEEF);
        tick();
        wen = 1'b0; alloc = 1'b0;
        #1;
        check("array_r5", 64'(rdata[31:0]), 64'hDEAD_BEEF);
        check("pend_before_rst", 64'(pend), 64'd1);
        rst_i = 1'b0;
        #1;
        check("rst_r5", 64'(rdata[31:0]), 64'd0);
        check("rst_pend", 64'(pend), 64'd0);
        tick();
        rst_i = 1'b1;

        // Write/bypass on reg3, both ports reading it
        wen = 1'b1; waddr = 5'd3; wdata = 32'h1234_5678; raddr = {5'd3, 5'd3};
        #1;
        check("bypass_r3", rdata, 64'h1234_5678_1234_5678);
        tick();
        wen = 1'b0;
        #1;
        check("array_r3", rdata, 64'h1234_5678_1234_5678);
        check("r3_nobusy", 64'(rbusy), 64'd0);
        tick();
        check("array_r3_later", 64'(rdata[63:32]), 64'h1234_5678);

        // Write to reg0 is discarded
        wen = 1'b1; waddr = 5'd0; wdata = 32'hFFFF_FFFF; raddr = {5'd3, 5'd0};
        #1;
        check("r0_bypass_zero", 64'(rdata[31:0]), 64'd0);
        tick();
        wen = 1'b0;
        #1;
        check("r0_array_zero", 64'(rdata[31:0]), 64'd0);

        // Scoreboard round trip on reg7
        alloc = 1'b1; alloc_addr = 5'd7; raddr = {5'd0, 5'd7};
        #1;
        check("r7_busy_not_yet", 64'(rbusy[0]), 64'd0);
        tick();
        alloc = 1'b0;
        #1;
        check("r7_busy", 64'(rbusy[0]), 64'd1);
        check("r7_pend1", 64'(pend), 64'd1);
        tick();
        wen = 1'b1; waddr = 5'd7; wdata = 32'hAAAA_0007;
        #1;
        check("r7_wb_busy_drop", 64'(rbusy[0]), 64'd0);
        check("r7_wb_bypass", 64'(rdata[31:0]), 64'hAAAA_0007);
        check("r7_pend_pre_edge", 64'(pend), 64'd1);
        tick();
        wen = 1'b0;
        #1;
        check("r7_pend0", 64'(pend), 64'd0);
        check("r7_busy_cleared", 64'(rbusy[0]), 64'd0);

        // Same-cycle alloc and writeback on busy reg9
        alloc = 1'b1; alloc_addr = 5'd9; raddr = {5'd0, 5'd9};
        tick();
        alloc = 1'b1; alloc_addr = 5'd9; wen = 1'b1; waddr = 5'd9; wdata = 32'h5555_0009;
        #1;
        check("r9_pend_pre", 64'(pend), 64'd1);
        check("r9_busy_hidden", 64'(rbusy[0]), 64'd0);
        tick();
        alloc = 1'b0; wen = 1'b0;
        #1;
        check("r9_data", 64'(rdata[31:0]), 64'h5555_0009);
        check("r9_still_busy", 64'(rbusy[0]), 64'd1);
        check("r9_pend_same", 64'(pend), 64'd1);
        wen = 1'b1; waddr = 5'd9; wdata = 32'h6666_0009;
        tick();
        wen = 1'b0;
        #1;
        check("r9_retired", 64'(pend), 64'd0);

        // Flush beats a same-cycle alloc; data write still lands
        alloc = 1'b1; alloc_addr = 5'd1;
        tick();
        alloc_addr = 5'd2;
        tick();
        alloc_addr = 5'd3;
        tick();
        alloc = 1'b0; raddr = {5'd1, 5'd2};
        #1;
        check("flush_setup_pend", 64'(pend), 64'd3);
        check("flush_setup_busy", 64'(rbusy), 64'b11);
        flush = 1'b1; alloc = 1'b1; alloc_addr = 5'd4;
        wen = 1'b1; waddr = 5'd1; wdata = 32'h0000_0077;
        tick();
        flush = 1'b0; alloc = 1'b0; wen = 1'b0; raddr = {5'd1, 5'd4};
        #1;
        check("flush_pend0", 64'(pend), 64'd0);
        check("flush_r4_busy", 64'(rbusy[0]), 64'd0);
        check("flush_r1_busy", 64'(rbusy[1]), 64'd0);
        check("flush_r1_data", 64'(rdata[63:32]), 64'h77);

        // Wide instance: four ports, mix of busy and idle registers
        m_wen = 1'b1; m_waddr = 5'd2; m_wdata = 16'h1111;
        tick();
        m_waddr = 5'd3; m_wdata = 16'h2222; m_alloc = 1'b1; m_alloc_addr = 5'd3;
        tick();
        m_waddr = 5'd4; m_wdata = 16'h3333; m_alloc_addr = 5'd0;
        tick();
        m_wen = 1'b0; m_alloc_addr = 5'd5;
        tick();
        m_alloc = 1'b0; m_raddr = {5'd5, 5'd4, 5'd3, 5'd2};
        #1;
        check("m_rdata", m_rdata, 64'h0000_3333_2222_1111);
        check("m_rbusy", 64'(m_rbusy), 64'b1010);
        check("m_pend", 64'(m_pend), 64'd2);
        m_raddr = {5'd0, 5'd0, 5'd3, 5'd3};
        #1;
        check("m_dup_rdata", m_rdata, 64'h0000_0000_2222_2222);
        check("m_dup_rbusy", 64'(m_rbusy), 64'b0011);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule

// File: doc/regfile_sb.md
# regfile_sb

Parametrised multi-read-port register file with same-cycle write bypass and an integrated scoreboard that tracks destination registers with an in-flight write. It replaces the fixed 2-read/1-write register file in the pipelined CPU ID stage. The per-port busy flags feed the hazard/stall logic. Register 0 is hardwired to zero and is never busy.

## Interface
Parameters:
- DATA_W, 32, register width in bits
- ADDR_W, 5, register address width; DEPTH = 2**ADDR_W registers
- N_RD, 2, number of read ports (1..4)

Ports:
- clk_i  in  1  clock; all state updates on the rising edge
- rst_i  in  1  asynchronous, active-low reset
- raddr_i  in  N_RD*ADDR_W  read addresses; port k at bits [k*ADDR_W +: ADDR_W]
- rdata_o  out  N_RD*DATA_W  read data; port k at bits [k*DATA_W +: DATA_W], combinational
- rbusy_o  out  N_RD  port k reads a register with a pending write
- wen_i  in  1  writeback enable
- waddr_i  in  ADDR_W  writeback address
- wdata_i  in  DATA_W  writeback data
- alloc_i  in  1  issue strobe: mark alloc_addr_i pending
- alloc_addr_i  in  ADDR_W  destination register being issued
- flush_i  in  1  clear all pending marks (pipeline flush)
- pend_cnt_o  out  ADDR_W+1  number of registers currently marked busy

## Operation
- State:
  - array reg[0..DEPTH-1] of DATA_W bits
  - busy[0..DEPTH-1] of 1 bit
- Write: on a rising edge with wen_i=1 and waddr_i!=0, reg[waddr_i] <= wdata_i. A write with waddr_i=0 is discarded.
- Read port k, combinational:
  - raddr=0 -> 0
  - else if wen_i and waddr_i==raddr -> wdata_i (bypass)
  - else -> reg[raddr]
- rbusy_o[k] = busy[raddr] & ~(wen_i & waddr_i==raddr). A retiring write clears the hazard in the same cycle. rbusy_o[k] is always 0 for raddr=0.
- Scoreboard next-state for register r != 0, in priority order:
  1. flush_i=1 -> busy[r] <= 0. Any alloc_i in the same cycle is ignored.
  2. alloc_i=1 and alloc_addr_i==r -> busy[r] <= 1. Allocation wins over a same-cycle writeback to r, because the new producer supersedes the retiring one.
  3. wen_i=1 and waddr_i==r -> busy[r] <= 0.
  4. Otherwise hold.
- busy[0] is constant 0. alloc_i to address 0 is a no-op.
- Allocating an already-busy register keeps it busy; there is no per-register count, so WAW collapses to one mark.
- A writeback to a non-busy register is legal: data is written and busy stays 0.
- flush_i does not affect data writes; wen_i in a flush cycle still updates the array.
- pend_cnt_o = popcount(busy), registered, matching the busy state after the edge. Range 0..DEPTH-1.

## Timing
- Reset (rst_i=0, asynchronous, immediate, including mid-operation):
  - all reg <= 0 and all busy <= 0, so pend_cnt_o=0
  - rdata_o=0 for every port, and rbusy_o=0 while wen_i=0
  - rdata_o/rbusy_o still follow the bypass terms combinationally during reset
- Write latency:
  - data is visible on rdata_o in the same cycle via bypass
  - the array holds it from the next cycle onward
- Alloc latency: busy is visible on rbusy_o one cycle after the alloc_i edge.
- Writeback clear: rbusy_o drops in the writeback cycle (combinational); busy bit clears at that edge.
- All read ports are independent. Identical addresses on several ports return identical data and busy.
- No handshake stalls inside the block; every input is sampled every cycle.

## Test plan
- Reset then read: assert rst_i=0 mid-stream after writing reg5=32'hDEAD_BEEF -> immediately rdata for raddr=5 is 0, pend_cnt_o=0.
- Write/bypass: wen_i=1, waddr=3, wdata=32'h1234_5678, raddr0=3 -> rdata0=32'h1234_5678 in the same cycle and every following cycle. A write to reg0 with 32'hFFFF_FFFF leaves reads of 0 returning 0.
- Scoreboard round trip:
  - alloc reg7 at cycle n -> rbusy0=1 for raddr0=7 from n+1, pend_cnt_o=1
  - writeback reg7 at cycle m -> rbusy0=0 in cycle m, pend_cnt_o=0 after the edge
- Same-cycle alloc and writeback on reg9 with reg9 busy -> reg9 takes the new data, busy stays 1, pend_cnt_o unchanged.
- Flush priority:
  - setup: allocate regs 1, 2, 3 -> pend_cnt_o=3
  - stimulus: flush_i=1 with alloc_i=1 on reg4 -> all busy 0 and pend_cnt_o=0 next cycle; reg4 not busy
- Multi-port (N_RD=4, DATA_W=16): four distinct busy/non-busy addresses read at once -> each port returns its own data and busy flag; the alloc of reg0 is ignored.
